// File: rtl/mult_sa_issue.sv
// Request front-end for a blocking shift-accumulate multiplier.
// Latency: request accepted in cycle 0, start pulse in cycle 1, response the cycle after the product returns.
// Backpressure: req_ready_o drops when the FIFO is full; no new operation starts while the response slot is occupied.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                empties the FIFO, drops the response, discards any in-flight product
//   req_*                  valid/ready request stream {tc_mode, a, b, tag}
//   mul_*                  blocking multiplier interface (start pulse, head operands, busy, product)
//   rsp_*                  valid/ready response stream {c, tag}
//   err_o                  sticky protocol error (product or prolonged busy while idle)
module mult_sa_issue #(
  parameter int unsigned ADw   = 8,
  parameter int unsigned BDw   = 8,
  parameter int unsigned TagDw = 4,
  parameter int unsigned Depth = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_tc_mode_i,
  input  logic [ADw-1:0]         req_a_i,
  input  logic [BDw-1:0]         req_b_i,
  input  logic [TagDw-1:0]       req_tag_i,
  output logic                   mul_en_po,
  output logic [1:0]             mul_tc_mode_o,
  output logic [ADw-1:0]         mul_a_o,
  output logic [BDw-1:0]         mul_b_o,
  input  logic                   mul_busy_i,
  input  logic                   mul_valid_i,
  input  logic [ADw+BDw-1:0]     mul_c_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [ADw+BDw-1:0]     rsp_c_o,
  output logic [TagDw-1:0]       rsp_tag_o,
  output logic                   err_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  typedef struct packed {
    logic [1:0]       tc;
    logic [ADw-1:0]   a;
    logic [BDw-1:0]   b;
    logic [TagDw-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrain
  } state_e;

  req_t               fifo_q [Depth];
  logic [PtrW:0]      wptr_q, wptr_d;
  logic [PtrW:0]      rptr_q, rptr_d;
  state_e             state_q, state_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ADw+BDw-1:0] rsp_c_q, rsp_c_d;
  logic [TagDw-1:0]   rsp_tag_q, rsp_tag_d;
  logic               err_q, err_d;
  logic               stall_q, stall_d;

  logic empty, full, push, pop, start, capture;
  req_t head, wr_entry;

  // Wrap-bit pointers: equal means empty, equal index with differing wrap bit means full.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                 (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign head  = fifo_q[rptr_q[PtrW-1:0]];

  assign wr_entry = '{tc: req_tc_mode_i, a: req_a_i, b: req_b_i, tag: req_tag_i};

  // A push during a flush is dropped; ready is plain !full (no pop bypass).
  assign req_ready_o = !full;
  assign push        = req_valid_i && req_ready_o && !flush_i;

  // Only start when the response slot is free or being drained this cycle,
  // so the captured product can never overwrite an unconsumed response.
  assign start   = (state_q == StIdle) && !empty && !mul_busy_i && !flush_i &&
                   (!rsp_valid_q || rsp_ready_i);
  assign capture = (state_q == StWait) && mul_valid_i && !flush_i;
  // The head stays in place for the whole operation so the multiplier inputs are stable.
  assign pop     = capture;

  assign mul_en_po     = start;
  assign mul_tc_mode_o = head.tc;
  assign mul_a_o       = head.a;
  assign mul_b_o       = head.b;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_c_o     = rsp_c_q;
  assign rsp_tag_o   = rsp_tag_q;
  assign err_o       = err_q;

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_c_d     = rsp_c_q;
    rsp_tag_d   = rsp_tag_q;
    err_d       = err_q;
    stall_d     = 1'b0;

    case (state_q)
      StIdle:  if (start) state_d = StWait;
      // A product arriving together with a flush is discarded and we go idle.
      StWait:  if (mul_valid_i) state_d = StIdle;
               else if (flush_i) state_d = StDrain;
      // Flushed operation still owns the multiplier; swallow its product.
      StDrain: if (mul_valid_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (push) wptr_d = wptr_q + (PtrW+1)'(1);

    if (flush_i)  rptr_d = wptr_q;
    else if (pop) rptr_d = rptr_q + (PtrW+1)'(1);

    if (flush_i) begin
      rsp_valid_d = 1'b0;
    end else if (capture) begin
      rsp_valid_d = 1'b1;
      rsp_c_d     = mul_c_i;
      rsp_tag_d   = head.tag;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end

    // Busy while idle with work queued is tolerated for one cycle only.
    stall_d = (state_q == StIdle) && mul_busy_i && !empty;
    if (((state_q == StIdle) && mul_valid_i) || (stall_d && stall_q)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) fifo_q[i] <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      state_q     <= StIdle;
      rsp_valid_q <= 1'b0;
      rsp_c_q     <= '0;
      rsp_tag_q   <= '0;
      err_q       <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      if (push) fifo_q[wptr_q[PtrW-1:0]] <= wr_entry;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_c_q     <= rsp_c_d;
      rsp_tag_q   <= rsp_tag_d;
      err_q       <= err_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: tb/tb_mult_sa_issue.sv
// Scoreboard bench for mult_sa_issue with a behavioural 10-cycle multiplier.
module tb_mult_sa_issue;

  logic        clk_i;
  logic        rst_ni;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_tc_mode_i;
  logic [7:0]  req_a_i;
  logic [7:0]  req_b_i;
  logic [3:0]  req_tag_i;
  logic        mul_en_po;
  logic [1:0]  mul_tc_mode_o;
  logic [7:0]  mul_a_o;
  logic [7:0]  mul_b_o;
  logic        mul_busy_i;
  logic        mul_valid_i;
  logic [15:0] mul_c_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [15:0] rsp_c_o;
  logic [3:0]  rsp_tag_o;
  logic        err_o;

  mult_sa_issue #(.ADw(8), .BDw(8), .TagDw(4), .Depth(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_tc_mode_i(req_tc_mode_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i),
    .mul_en_po(mul_en_po), .mul_tc_mode_o(mul_tc_mode_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_busy_i(mul_busy_i), .mul_valid_i(mul_valid_i), .mul_c_i(mul_c_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_c_o(rsp_c_o),
    .rsp_tag_o(rsp_tag_o), .err_o(err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int vectors;
  int miscompares;

  typedef struct {
    logic [15:0] c;
    logic [3:0]  tag;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference product: each operand read as signed or unsigned, then plain multiplication.
  function automatic logic [15:0] ref_prod(input logic [1:0] tc, input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    sa = tc[0] ? int'($signed(a)) : int'(a);
    sb = tc[1] ? int'($signed(b)) : int'(b);
    return 16'(sa * sb);
  endfunction

  // Behavioural multiplier: start seen in cycle t, busy t+1..t+8, product valid in t+9.
  int          mcnt;
  logic        m_valid;
  logic [15:0] m_c, m_res;
  logic        spur_v;
  assign mul_valid_i = m_valid | spur_v;
  assign mul_c_i     = m_valid ? m_res : 16'hBEEF;

  initial begin
    mcnt = 0; m_valid = 1'b0; mul_busy_i = 1'b0; m_c = '0; m_res = '0;
    forever begin
      @(negedge clk_i);
      if (rst_ni && mul_en_po) begin
        check("en_while_mult_busy", 32'(mcnt == 0), 32'd1);
        m_c  = ref_prod(mul_tc_mode_o, mul_a_o, mul_b_o);
        mcnt = 9;
      end
      @(posedge clk_i);
      #1;
      m_valid = 1'b0;
      if (!rst_ni) begin
        mcnt = 0;
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          m_valid = 1'b1;
          m_res   = m_c;
        end
      end
      mul_busy_i = (mcnt > 0);
    end
  end

  // Monitor: expectations pushed on request handshake, popped on response handshake.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        exp_q.delete();
      end else begin
        if (rsp_valid_o && rsp_ready_i) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'(exp_q.size()), 32'd1);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rsp_c", 32'(rsp_c_o), 32'(e.c));
            check("rsp_tag", 32'(rsp_tag_o), 32'(e.tag));
          end
        end
        if (flush_i) exp_q.delete();
        else if (req_valid_i && req_ready_o)
          exp_q.push_back('{c: ref_prod(req_tc_mode_i, req_a_i, req_b_i), tag: req_tag_i});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Holds the request until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] tc, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
    logic acc;
    int   n;
    req_valid_i = 1'b1; req_tc_mode_i = tc; req_a_i = a; req_b_i = b; req_tag_i = tag;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk_i);
      acc = req_ready_o;
      tick();
      n++;
    end
    req_valid_i = 1'b0;
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
  endtask

  // Counts cycles (0 = current) until rsp_valid_o; ends at that cycle's negedge.
  task automatic wait_rsp(output int n);
    n = 0;
    @(negedge clk_i);
    while (!rsp_valid_o && n < 200) begin
      tick();
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) check("rsp_timeout", 32'(rsp_valid_o), 32'd1);
  endtask

  initial begin
    int n, cnt;
    logic acc;
    vectors = 0; miscompares = 0;
    rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_tc_mode_i = '0;
    req_a_i = '0; req_b_i = '0; req_tag_i = '0; rsp_ready_i = 1'b0; spur_v = 1'b0;

    // Reset state
    #12;
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rsp_c", 32'(rsp_c_o), 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_en", 32'(mul_en_po), 32'd0);
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_mul_a", 32'(mul_a_o), 32'd0);
    check("rst_mul_b", 32'(mul_b_o), 32'd0);
    check("rst_mul_tc", 32'(mul_tc_mode_o), 32'd0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // Unsigned request: accept cyc0, start cyc1, response cyc11
    rsp_ready_i = 1'b1;
    send(2'b00, 8'd200, 8'd3, 4'd5);
    @(negedge clk_i);
    check("en_cycle1", 32'(mul_en_po), 32'd1);
    tick();
    wait_rsp(n);
    check("latency_cyc11", 32'(n), 32'd9);
    check("unsigned_c", 32'(rsp_c_o), 32'h258);
    check("unsigned_tag", 32'(rsp_tag_o), 32'd5);
    tick();

    // Signed pair back to back: also shows one product per 10 cycles
    send(2'b11, 8'hF9, 8'd5, 4'd1);
    send(2'b01, 8'hFF, 8'hFF, 4'd2);
    wait_rsp(n);
    check("signed_lat", 32'(n), 32'd9);
    check("signed11_c", 32'(rsp_c_o), 32'hFFDD);
    tick();
    wait_rsp(n);
    check("throughput_gap", 32'(n), 32'd9);
    check("signed01_c", 32'(rsp_c_o), 32'hFF01);
    check("signed01_tag", 32'(rsp_tag_o), 32'd2);
    tick();

    // Backpressure: response held, FIFO fills, no second start
    rsp_ready_i = 1'b0;
    send(2'b00, 8'd10, 8'd11, 4'd7);
    send(2'b00, 8'd12, 8'd13, 4'd8);
    @(negedge clk_i);
    check("bp_full_after_2", 32'(req_ready_o), 32'd0);
    tick();
    send(2'b10, 8'h80, 8'h02, 4'd9);
    @(negedge clk_i);
    check("bp_full_after_3", 32'(req_ready_o), 32'd0);
    check("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("bp_rsp_c", 32'(rsp_c_o), 32'd110);
    cnt = 0;
    repeat (20) begin
      tick();
      @(negedge clk_i);
      if (mul_en_po) cnt++;
    end
    check("bp_no_second_en", 32'(cnt), 32'd0);
    check("bp_rsp_held_c", 32'(rsp_c_o), 32'd110);
    check("bp_rsp_held_tag", 32'(rsp_tag_o), 32'd7);
    tick();
    rsp_ready_i = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    tick(); tick();

    // Flush in WAIT at cyc5: in-flight product and queued request dropped
    send(2'b00, 8'd33, 8'd3, 4'd10);
    send(2'b00, 8'd44, 8'd4, 4'd11);
    tick(); tick(); tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    cnt = 0;
    repeat (15) begin
      @(negedge clk_i);
      if (rsp_valid_o) cnt++;
      tick();
    end
    check("flush_no_rsp", 32'(cnt), 32'd0);
    check("flush_fifo_empty", 32'(req_ready_o), 32'd1);
    send(2'b00, 8'd7, 8'd9, 4'd12);
    wait_rsp(n);
    check("post_flush_lat", 32'(n), 32'd10);
    check("post_flush_c", 32'(rsp_c_o), 32'd63);
    tick();
    check("err_clean", 32'(err_o), 32'd0);

    // Spurious product while idle
    rsp_ready_i = 1'b0;
    tick();
    spur_v = 1'b1;
    tick();
    spur_v = 1'b0;
    @(negedge clk_i);
    check("spur_err", 32'(err_o), 32'd1);
    check("spur_rsp_valid", 32'(rsp_valid_o), 32'd0);
    repeat (5) tick();
    check("spur_err_sticky", 32'(err_o), 32'd1);
    rsp_ready_i = 1'b1;

    // Reset mid-operation at cyc6
    send(2'b00, 8'd50, 8'd60, 4'd3);
    repeat (5) tick();
    rst_ni = 1'b0;
    #1;
    check("mrst_en", 32'(mul_en_po), 32'd0);
    check("mrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("mrst_rsp_c", 32'(rsp_c_o), 32'd0);
    check("mrst_err", 32'(err_o), 32'd0);
    check("mrst_req_ready", 32'(req_ready_o), 32'd1);
    check("mrst_mul_a", 32'(mul_a_o), 32'd0);
    tick(); tick();
    rst_ni = 1'b1;
    tick(); tick();

    // Randomised traffic with random backpressure and occasional flush
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk_i);
      acc = req_valid_i && req_ready_o;
      tick();
      if (!req_valid_i || acc || flush_i) begin
        req_valid_i   = ($urandom_range(0, 2) != 0);
        req_tc_mode_i = 2'($urandom_range(0, 3));
        req_a_i       = 8'($urandom);
        req_b_i       = 8'($urandom);
        req_tag_i     = 4'($urandom);
      end
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 99) == 0);
    end
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    rsp_ready_i = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || mcnt != 0) && n < 300) begin tick(); n++; end
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    tick(); tick();
    check("rand_err", 32'(err_o), 32'd0);
    check("rand_idle_rsp", 32'(rsp_valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1);
  end

endmodule
